// File: rtl/float_to_signed_int_seq_if.sv
// Request/result bundle for the float-to-signed-int converter.
// The master drives operands; the slave (converter) returns the result and status.
interface float_to_signed_int_seq_if;
  logic        start;
  logic [31:0] FP_val;
  logic        busy;
  logic        done;
  logic [31:0] signed_int_val;
  logic        ovfl;
  logic        inexact;

  modport master (
    output start, FP_val,
    input  busy, done, signed_int_val, ovfl, inexact
  );

  modport slave (
    input  start, FP_val,
    output busy, done, signed_int_val, ovfl, inexact
  );
endinterface

// File: rtl/float_to_signed_int_seq.sv
// IEEE-754 single to 32-bit signed integer, truncating toward zero, with
// saturation and an iterative mantissa aligner moving SHIFT_STEP bits per clock.
module float_to_signed_int_seq #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  float_to_signed_int_seq_if.slave  bus
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_FINISH} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sign, w_sign_nxt;
  logic             r_left, w_left_nxt;
  logic             r_special, w_special_nxt;
  logic [W-1:0]     r_spec_val, w_spec_val_nxt;
  logic [W-1:0]     r_mag, w_mag_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf_wk, w_ovf_wk_nxt;
  logic             r_inx_wk, w_inx_wk_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [W-1:0]     r_result, w_result_nxt;
  logic             r_ovfl, w_ovfl_nxt;
  logic             r_inexact, w_inexact_nxt;

  logic             w_in_sign;
  logic [7:0]       w_in_exp;
  logic [22:0]      w_in_frac;
  logic [CNT_W-1:0] w_step;
  logic [W-1:0]     w_drop_mask;

  assign w_in_sign = bus.FP_val[31];
  assign w_in_exp  = bus.FP_val[30:23];
  assign w_in_frac = bus.FP_val[22:0];

  // Bits moved this ALIGN cycle and the mask of bits a right shift discards
  assign w_step      = (r_cnt > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : r_cnt;
  assign w_drop_mask = (W'(1) << w_step) - W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sign     <= 1'b0;
      r_left     <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_ovf_wk   <= 1'b0;
      r_inx_wk   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_ovfl     <= 1'b0;
      r_inexact  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sign     <= w_sign_nxt;
      r_left     <= w_left_nxt;
      r_special  <= w_special_nxt;
      r_spec_val <= w_spec_val_nxt;
      r_mag      <= w_mag_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf_wk   <= w_ovf_wk_nxt;
      r_inx_wk   <= w_inx_wk_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_result   <= w_result_nxt;
      r_ovfl     <= w_ovfl_nxt;
      r_inexact  <= w_inexact_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sign_nxt     = r_sign;
    w_left_nxt     = r_left;
    w_special_nxt  = r_special;
    w_spec_val_nxt = r_spec_val;
    w_mag_nxt      = r_mag;
    w_cnt_nxt      = r_cnt;
    w_ovf_wk_nxt   = r_ovf_wk;
    w_inx_wk_nxt   = r_inx_wk;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_result_nxt   = r_result;
    w_ovfl_nxt     = r_ovfl;
    w_inexact_nxt  = r_inexact;

    case (r_state)
      S_IDLE: begin
        // The cycle carrying the done pulse never accepts a new request
        if (bus.start && !r_done) begin
          w_state_nxt    = S_ALIGN;
          w_busy_nxt     = 1'b1;
          w_sign_nxt     = w_in_sign;
          w_mag_nxt      = W'({1'b1, w_in_frac});
          w_ovf_wk_nxt   = 1'b0;
          w_inx_wk_nxt   = 1'b0;
          w_special_nxt  = 1'b0;
          w_spec_val_nxt = '0;
          w_cnt_nxt      = '0;
          w_left_nxt     = 1'b0;
          if (w_in_exp == 8'd255) begin
            w_special_nxt  = 1'b1;
            w_spec_val_nxt = (w_in_sign || (w_in_frac != '0)) ? INT_MIN : INT_MAX;
            w_ovf_wk_nxt   = 1'b1;
          end else if (w_in_exp >= 8'd158) begin
            w_special_nxt = 1'b1;
            if (w_in_sign && (w_in_exp == 8'd158) && (w_in_frac == '0)) begin
              w_spec_val_nxt = INT_MIN;
            end else begin
              w_spec_val_nxt = w_in_sign ? INT_MIN : INT_MAX;
              w_ovf_wk_nxt   = 1'b1;
            end
          end else if (w_in_exp < 8'd127) begin
            w_special_nxt  = 1'b1;
            w_spec_val_nxt = '0;
            w_inx_wk_nxt   = (w_in_exp != '0) || (w_in_frac != '0);
          end else if (w_in_exp <= 8'd150) begin
            w_cnt_nxt = CNT_W'(8'd150 - w_in_exp);
          end else begin
            w_cnt_nxt  = CNT_W'(w_in_exp - 8'd150);
            w_left_nxt = 1'b1;
          end
        end
      end

      S_ALIGN: begin
        if (r_cnt != '0) begin
          if (r_left) begin
            w_mag_nxt = r_mag << w_step;
          end else begin
            w_mag_nxt    = r_mag >> w_step;
            w_inx_wk_nxt = r_inx_wk | (|(r_mag & w_drop_mask));
          end
          w_cnt_nxt = r_cnt - w_step;
        end else begin
          w_state_nxt = S_FINISH;
        end
      end

      S_FINISH: begin
        w_result_nxt  = r_special ? r_spec_val : (r_sign ? (~r_mag + W'(1)) : r_mag);
        w_ovfl_nxt    = r_ovf_wk;
        w_inexact_nxt = r_inx_wk;
        w_done_nxt    = 1'b1;
        w_busy_nxt    = 1'b0;
        w_state_nxt   = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.signed_int_val = r_result;
  assign bus.ovfl           = r_ovfl;
  assign bus.inexact        = r_inexact;

endmodule

// File: tb/tb_float_to_signed_int_seq.sv
// Directed-table and random checks of the float-to-int converter at SHIFT_STEP 1, 4 and 8,
// plus held-start, done-cycle rejection and mid-conversion reset sequences.
module tb_float_to_signed_int_seq;

  localparam logic [31:0] MAXI = 32'h7FFF_FFFF;
  localparam logic [31:0] MINI = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] fp;

  always #5 clk = ~clk;

  float_to_signed_int_seq_if if1 ();
  float_to_signed_int_seq_if if4 ();
  float_to_signed_int_seq_if if8 ();

  assign if1.start = start;  assign if1.FP_val = fp;
  assign if4.start = start;  assign if4.FP_val = fp;
  assign if8.start = start;  assign if8.FP_val = fp;

  float_to_signed_int_seq #(.SHIFT_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  float_to_signed_int_seq #(.SHIFT_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  float_to_signed_int_seq #(.SHIFT_STEP(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  logic [31:0] o_val  [3];
  logic        o_done [3];
  logic        o_busy [3];
  logic        o_ovf  [3];
  logic        o_inx  [3];

  assign o_val[0] = if1.signed_int_val; assign o_done[0] = if1.done; assign o_busy[0] = if1.busy;
  assign o_val[1] = if4.signed_int_val; assign o_done[1] = if4.done; assign o_busy[1] = if4.busy;
  assign o_val[2] = if8.signed_int_val; assign o_done[2] = if8.done; assign o_busy[2] = if8.busy;
  assign o_ovf[0] = if1.ovfl; assign o_inx[0] = if1.inexact;
  assign o_ovf[1] = if4.ovfl; assign o_inx[1] = if4.inexact;
  assign o_ovf[2] = if8.ovfl; assign o_inx[2] = if8.inexact;

  int steps [3] = '{1, 4, 8};

  int total = 0;
  int bad   = 0;

  int          got_lat [3];
  logic [31:0] got_val [3];
  logic        got_ovf [3];
  logic        got_inx [3];

  typedef struct {
    logic [31:0] fp;
    logic [31:0] val;
    logic        ovf;
    logic        inx;
    int          lat1;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Reference conversion by 64-bit integer arithmetic on the unpacked fields
  task automatic model(input logic [31:0] f, output logic [31:0] v, output logic ov,
                       output logic inx, output int sh);
    logic        s;
    int          ee;
    logic [22:0] fr;
    longint      m;
    longint      mag;
    s  = f[31];
    ee = int'(f[30:23]) - 127;
    fr = f[22:0];
    v = '0; ov = 1'b0; inx = 1'b0; sh = 0;
    if (f[30:23] == 8'hFF) begin
      ov = 1'b1;
      v  = (s || fr != '0) ? MINI : MAXI;
    end else if (ee < 0) begin
      inx = (f[30:0] != '0);
    end else if (ee > 31) begin
      ov = 1'b1;
      v  = s ? MINI : MAXI;
    end else begin
      m = longint'({1'b1, fr});
      if (ee >= 23) begin
        mag = m << (ee - 23);
        sh  = (ee <= 30) ? ee - 23 : 0;
      end else begin
        mag = m >> (23 - ee);
        inx = ((mag << (23 - ee)) != m);
        sh  = 23 - ee;
      end
      if (!s && mag > 64'sh7FFF_FFFF) begin
        ov = 1'b1; v = MAXI; inx = 1'b0;
      end else if (s && mag > 64'sh8000_0000) begin
        ov = 1'b1; v = MINI; inx = 1'b0;
      end else begin
        v = s ? 32'(-mag) : 32'(mag);
      end
    end
  endtask

  // One request to all three converters; records latency and results per instance
  task automatic run_one(input logic [31:0] f);
    @(negedge clk);
    start = 1'b1;
    fp    = f;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("busy_on_accept[%0d]", k), 32'(o_busy[k]), 32'd1);
    @(negedge clk);
    start = 1'b0;
    fp    = $urandom;
    for (int k = 0; k < 3; k++) got_lat[k] = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (o_done[k] && got_lat[k] < 0) begin
          got_lat[k] = c;
          got_val[k] = o_val[k];
          got_ovf[k] = o_ovf[k];
          got_inx[k] = o_inx[k];
        end
      end
      if (got_lat[0] >= 0 && got_lat[1] >= 0 && got_lat[2] >= 0) break;
    end
    @(posedge clk);
  endtask

  task automatic check_vec(input logic [31:0] f, input logic [31:0] ev, input logic eo,
                           input logic ei, input int elat1);
    logic [31:0] mv;
    logic        mo;
    logic        mi;
    int          sh;
    int          elat;
    model(f, mv, mo, mi, sh);
    run_one(f);
    for (int k = 0; k < 3; k++) begin
      elat = (k == 0 && elat1 > 0) ? elat1 : 2 + (sh + steps[k] - 1) / steps[k];
      chk($sformatf("val %h s%0d", f, steps[k]), got_val[k], ev);
      chk($sformatf("ovfl %h s%0d", f, steps[k]), 32'(got_ovf[k]), 32'(eo));
      chk($sformatf("inexact %h s%0d", f, steps[k]), 32'(got_inx[k]), 32'(ei));
      chk($sformatf("latency %h s%0d", f, steps[k]), 32'(got_lat[k]), 32'(elat));
    end
  endtask

  initial begin
    int          d1;
    int          d2;
    int          ndone;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] f;
    logic [31:0] mv;
    logic        mo;
    logic        mi;
    int          sh;

    vecs[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
    vecs[1]  = '{32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 25};
    vecs[2]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 2};
    vecs[3]  = '{32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 9};
    vecs[4]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2};
    vecs[5]  = '{32'h4F32_D05E, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    vecs[6]  = '{32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
    vecs[7]  = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    vecs[8]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2};
    vecs[10] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2};
    vecs[11] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2};
    vecs[12] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9};
    vecs[13] = '{32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 9};
    vecs[14] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 2};
    vecs[15] = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    vecs[16] = '{32'h42F6_E979, 32'h0000_007B, 1'b0, 1'b1, 19};
    vecs[17] = '{32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 2};
    vecs[18] = '{32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 24};
    vecs[19] = '{32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 25};

    rst   = 1'b1;
    start = 1'b0;
    fp    = '0;
    #22;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset val[%0d]", k), o_val[k], 32'd0);
      chk($sformatf("reset flags[%0d]", k),
          {28'd0, o_busy[k], o_done[k], o_ovf[k], o_inx[k]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++)
      check_vec(vecs[i].fp, vecs[i].val, vecs[i].ovf, vecs[i].inx, vecs[i].lat1);

    for (int i = 0; i < 1000; i++) begin
      f = $urandom;
      if (i % 4 != 0) f[30:23] = 8'($urandom_range(100, 160));
      model(f, mv, mo, mi, sh);
      check_vec(f, mv, mo, mi, 0);
    end

    // start held high; FP_val only carries the wanted operand on the edges that may accept
    d1 = -1; d2 = -1; v1 = '0; v2 = '0;
    @(negedge clk);
    start = 1'b1;
    fp    = 32'h3F80_0000;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      fp = (c == 27) ? 32'h4E80_0000 : ((c % 2 == 1) ? 32'h7FC0_0000 : 32'hFF80_0000);
      @(posedge clk);
      #1;
      if (o_done[0]) begin
        if (d1 < 0) begin d1 = c; v1 = o_val[0]; end
        else if (d2 < 0) begin d2 = c; v2 = o_val[0]; end
      end
      if (c == 26) begin
        chk("held_busy_after_done", 32'(o_busy[0]), 32'd0);
        chk("held_done_one_cycle", 32'(o_done[0]), 32'd0);
      end
      if (c == 27) chk("held_busy_reaccept", 32'(o_busy[0]), 32'd1);
    end
    chk("held_first_done_cycle", 32'(d1), 32'd25);
    chk("held_first_val", v1, 32'h0000_0001);
    chk("held_second_done_cycle", 32'(d2), 32'd36);
    chk("held_second_val", v2, 32'h4000_0000);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(posedge clk);

    // Leave nonzero outputs behind so the asynchronous clear is visible
    check_vec(32'h7FC0_0000, MINI, 1'b1, 1'b0, 2);
    check_vec(32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 25);

    @(negedge clk);
    start = 1'b1;
    fp    = 32'h3F80_0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_rst val[%0d]", k), o_val[k], 32'd0);
      chk($sformatf("async_rst flags[%0d]", k),
          {28'd0, o_busy[k], o_done[k], o_ovf[k], o_inx[k]}, 32'd0);
    end
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (o_done[0] || o_done[1] || o_done[2]) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 32'd0);
    check_vec(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_to_signed_int_seq.md
Name: float_to_signed_int_seq

Overview:
Multi-cycle converter from IEEE-754 single-precision to 32-bit two's-complement signed integer. It is the inverse of the combinational signed-int-to-float path.
- Rounding: truncates toward zero.
- Out-of-range inputs saturate; overflow and inexact are flagged.
- Mantissa alignment uses an iterative shifter (SHIFT_STEP bits per clock) to keep area small.
- Used by the FP datapath for float-to-int conversion, e.g. classifier output index.

Parameters:
SHIFT_STEP, 1, mantissa bits shifted per ALIGN cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while busy=0
FP_val  input  32  single-precision operand; captured on the accepting edge
busy  output  1  high from the accepting edge until the edge that asserts done
done  output  1  one-cycle pulse; result and flags valid from this cycle
signed_int_val  output  32  signed result; held until the next accepted start
ovfl  output  1  set for NaN, Inf, or magnitude ≥ 2^31 (except exactly -2^31)
inexact  output  1  set when nonzero fraction bits are discarded

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, signed_int_val=0, ovfl=0, inexact=0; any in-flight conversion is abandoned.
- States: IDLE, ALIGN, FINISH.
- IDLE → ALIGN on the edge where start=1.
  - That edge captures sign s, exponent E=FP_val[30:23], and mag={1,FP_val[22:0]} (32-bit register).
  - Sets busy=1, clears ovfl and inexact, and computes e=E-127.
- Classification, done on the capturing edge:
  - E=255 (NaN/Inf): special, result 0x80000000 if NaN or s=1, 0x7FFFFFFF if +Inf; ovfl=1.
  - e≥31: saturate unless s=1, E=158, frac=0 (exactly -2^31 → 0x80000000, ovfl=0). Otherwise result 0x7FFFFFFF (s=0) or 0x80000000 (s=1), ovfl=1.
  - e<0 (including zero and denormals): result 0. inexact=1 if E!=0 or frac!=0.
  - 0≤e≤22: right shift, shamt=23-e.
  - 23≤e≤30: left shift, shamt=e-23.
  - Special cases use shamt=0.
- ALIGN: while cnt>0, shift mag by min(SHIFT_STEP,cnt) bits and decrement cnt by the same amount.
  - On right shifts, OR every discarded 1 bit into inexact.
  - When cnt==0, go to FINISH with no shift that cycle.
- FINISH:
  - signed_int_val ← special value if special, else (s ? -mag : mag). -0 yields 0.
  - done=1 for one cycle, busy=0, next state IDLE.
- Latency: done is high 2 + ceil(shamt/SHIFT_STEP) clocks after the accepting edge. Maximum is 25 with SHIFT_STEP=1.
- start while busy=1: ignored, no queuing.
- start in the same cycle as done: not accepted. The first acceptable edge is the next one, i.e. the cycle after done, when busy=0.
- Outputs change only at FINISH or on reset. FP_val may change freely after capture.
- Magnitude never exceeds 2^31-1 on non-special paths, since e≤30.

Test Plan:
- SHIFT_STEP=1, FP_val=0x3F800000 (1.0) → done exactly 25 clocks after the accept edge; signed_int_val=1, ovfl=0, inexact=0.
- FP_val=0xBFC00000 (-1.5) → signed_int_val=0xFFFFFFFF (-1), inexact=1. FP_val=0x3F000000 (0.5) → 0, inexact=1, done after 2 clocks.
- FP_val=0x4E800000 (2^30) → 0x40000000, latency 9. FP_val=0xCF000000 (-2^31) → 0x80000000, ovfl=0. FP_val=0x4F32D05E (~3e9) → 0x7FFFFFFF, ovfl=1. FP_val=0x7FC00000 (NaN) → 0x80000000, ovfl=1.
- Random sweep of 1000 operands, SHIFT_STEP ∈ {1,4,8} → result matches $rtoi of $bitstoshortreal with saturation; latency matches the formula.
- start held high continuously, FP_val toggling → each conversion uses the value captured on its accept edge; no acceptance while busy or in the done cycle.
- rst pulsed mid-ALIGN on a 1.0 conversion → all outputs 0 immediately (asynchronously); no done pulse; the next start converts correctly.
